// File: rtl/me_pkg.sv
// Shared widths, state encoding and raster-walk helper for the ME search controller.
package me_pkg;
  localparam int SAD_W    = 17;
  localparam int COST_W   = 18;
  localparam int MV_W_DEF = 6;
  localparam int CRD_W    = 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} me_state_t;

  typedef struct packed {
    logic signed [CRD_W-1:0] u;
    logic signed [CRD_W-1:0] v;
  } cand_t;

  // u sweeps -r..r, then wraps to -r and v advances; v > r means the window is exhausted.
  function automatic cand_t raster_step(input cand_t c, input logic signed [CRD_W-1:0] r);
    cand_t n;
    if (c.u < r) begin
      n.u = c.u + CRD_W'(1);
      n.v = c.v;
    end else begin
      n.u = -r;
      n.v = c.v + CRD_W'(1);
    end
    return n;
  endfunction
endpackage

// File: rtl/me_cost_calc.sv
// Candidate cost: SAD plus lambda times the MV rate estimate |du|+|dv|.
module me_cost_calc import me_pkg::*; #(
  parameter int MV_W = MV_W_DEF
) (
  input  logic signed [MV_W-1:0]   i_mv_u,
  input  logic signed [MV_W-1:0]   i_mv_v,
  input  logic signed [MV_W-1:0]   i_pmv_u,
  input  logic signed [MV_W-1:0]   i_pmv_v,
  input  logic        [7:0]        i_lambda,
  input  logic        [SAD_W-1:0]  i_sad,
  output logic        [COST_W-1:0] o_cost
);
  logic signed [MV_W:0] w_du;
  logic signed [MV_W:0] w_dv;
  logic        [MV_W:0] w_abs_u;
  logic        [MV_W:0] w_abs_v;
  logic        [7:0]    w_bits;
  logic        [15:0]   w_rate;

  // One guard bit keeps the difference exact before taking the magnitude.
  assign w_du    = {i_mv_u[MV_W-1], i_mv_u} - {i_pmv_u[MV_W-1], i_pmv_u};
  assign w_dv    = {i_mv_v[MV_W-1], i_mv_v} - {i_pmv_v[MV_W-1], i_pmv_v};
  assign w_abs_u = w_du[MV_W] ? -w_du : w_du;
  assign w_abs_v = w_dv[MV_W] ? -w_dv : w_dv;
  assign w_bits  = 8'(w_abs_u) + 8'(w_abs_v);
  assign w_rate  = 16'(i_lambda) * 16'(w_bits);
  assign o_cost  = COST_W'(i_sad) + COST_W'(w_rate);
endmodule

// File: rtl/me_search_ctrl.sv
// Full-search integer-pel ME controller: batches raster candidates onto NENG SAD engines.
// Optional ME_EARLY_TERM_EN stops the search once the best cost reaches cmd_thresh.
module me_search_ctrl import me_pkg::*; #(
  parameter int NENG  = 4,
  parameter int MAX_R = 8,
  parameter int MV_W  = MV_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [4:0]               cmd_radius,
  input  logic signed [MV_W-1:0]   cmd_pmv_u,
  input  logic signed [MV_W-1:0]   cmd_pmv_v,
  input  logic [7:0]               cmd_lambda,
  input  logic [COST_W-1:0]        cmd_thresh,
  output logic [NENG-1:0]          eng_start,
  output logic [NENG*MV_W-1:0]     eng_u,
  output logic [NENG*MV_W-1:0]     eng_v,
  output logic                     fetch_go,
  input  logic [NENG-1:0]          eng_done,
  input  logic [NENG*SAD_W-1:0]    eng_sad,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [MV_W-1:0]   res_mv_u,
  output logic signed [MV_W-1:0]   res_mv_v,
  output logic [COST_W-1:0]        res_cost
);
  me_state_t               r_state;
  logic                    r_cmd_ready, r_fetch_go, r_res_valid, r_more;
  logic [NENG-1:0]         r_eng_start, r_active, r_sticky;
  logic signed [MV_W-1:0]  r_eng_u [NENG];
  logic signed [MV_W-1:0]  r_eng_v [NENG];
  logic [SAD_W-1:0]        r_sad   [NENG];
  logic signed [MV_W-1:0]  r_res_mv_u, r_res_mv_v, r_best_u, r_best_v, r_pmv_u, r_pmv_v;
  logic [COST_W-1:0]       r_res_cost, r_best_cost;
  logic signed [CRD_W-1:0] r_radius;
  logic [7:0]              r_lambda;
  cand_t                   r_cur;

  logic signed [CRD_W-1:0] w_cmd_r, w_gen_r;
  cand_t                   w_walk, w_next_cur;
  cand_t                   w_cand [NENG];
  logic [NENG-1:0]         w_mask;
  logic                    w_more, w_eval, w_stop, w_issue;
  logic [COST_W-1:0]       w_cost [NENG];
  logic [COST_W-1:0]       w_sel_cost;
  logic signed [MV_W-1:0]  w_sel_u, w_sel_v;

  assign w_cmd_r = (int'(cmd_radius) > MAX_R) ? CRD_W'(MAX_R) : CRD_W'(cmd_radius);

  // Next batch starts at (-R,-R) from the incoming command, else from the saved raster position.
  always_comb begin
    w_gen_r = (r_state == S_IDLE) ? w_cmd_r : r_radius;
    if (r_state == S_IDLE) begin
      w_walk.u = -w_cmd_r;
      w_walk.v = -w_cmd_r;
    end else begin
      w_walk = r_cur;
    end
    w_mask = '0;
    for (int i = 0; i < NENG; i++) begin
      w_cand[i] = w_walk;
      if (w_walk.v <= w_gen_r) begin
        w_mask[i] = 1'b1;
        w_walk    = raster_step(w_walk, w_gen_r);
      end
    end
    w_next_cur = w_walk;
    w_more     = (w_walk.v <= w_gen_r);
  end

  for (genvar g = 0; g < NENG; g++) begin : g_eng
    me_cost_calc #(.MV_W(MV_W)) u_cost (
      .i_mv_u  (r_eng_u[g]),
      .i_mv_v  (r_eng_v[g]),
      .i_pmv_u (r_pmv_u),
      .i_pmv_v (r_pmv_v),
      .i_lambda(r_lambda),
      .i_sad   (r_sad[g]),
      .o_cost  (w_cost[g])
    );
    assign eng_u[g*MV_W +: MV_W] = r_eng_u[g];
    assign eng_v[g*MV_W +: MV_W] = r_eng_v[g];
  end

  // Strict less-than scanned from engine 0 keeps the earliest raster candidate on ties.
  always_comb begin
    w_sel_cost = r_best_cost;
    w_sel_u    = r_best_u;
    w_sel_v    = r_best_v;
    for (int i = 0; i < NENG; i++) begin
      if (r_active[i] && (w_cost[i] < w_sel_cost)) begin
        w_sel_cost = w_cost[i];
        w_sel_u    = r_eng_u[i];
        w_sel_v    = r_eng_v[i];
      end
    end
  end

`ifdef ME_EARLY_TERM_EN
  logic [COST_W-1:0] r_thresh;
  assign w_stop = !r_more || (w_sel_cost <= r_thresh);
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^cmd_thresh;
  assign w_stop = !r_more;
`endif

  assign w_eval  = (r_state == S_WAIT) && (r_sticky == r_active);
  assign w_issue = ((r_state == S_IDLE) && cmd_valid) || (w_eval && !w_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_eng_start <= '0;
      r_fetch_go  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_mv_u  <= '0;
      r_res_mv_v  <= '0;
      r_res_cost  <= '0;
      r_radius    <= '0;
      r_pmv_u     <= '0;
      r_pmv_v     <= '0;
      r_lambda    <= '0;
      r_cur       <= '0;
      r_more      <= 1'b0;
      r_active    <= '0;
      r_sticky    <= '0;
      r_best_cost <= '1;
      r_best_u    <= '0;
      r_best_v    <= '0;
      for (int i = 0; i < NENG; i++) begin
        r_eng_u[i] <= '0;
        r_eng_v[i] <= '0;
        r_sad[i]   <= '0;
      end
`ifdef ME_EARLY_TERM_EN
      r_thresh    <= '0;
`endif
    end else begin
      r_eng_start <= '0;
      r_fetch_go  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_radius    <= w_cmd_r;
            r_pmv_u     <= cmd_pmv_u;
            r_pmv_v     <= cmd_pmv_v;
            r_lambda    <= cmd_lambda;
`ifdef ME_EARLY_TERM_EN
            r_thresh    <= cmd_thresh;
`endif
            r_best_cost <= '1;
            r_best_u    <= '0;
            r_best_v    <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_eval) begin
            r_best_cost <= w_sel_cost;
            r_best_u    <= w_sel_u;
            r_best_v    <= w_sel_v;
            if (w_stop) begin
              r_res_valid <= 1'b1;
              r_res_mv_u  <= w_sel_u;
              r_res_mv_v  <= w_sel_v;
              r_res_cost  <= w_sel_cost;
              r_state     <= S_RESULT;
            end else begin
              r_state     <= S_ISSUE;
            end
          end else begin
            for (int i = 0; i < NENG; i++) begin
              if (eng_done[i] && r_active[i] && !r_sticky[i]) begin
                r_sticky[i] <= 1'b1;
                r_sad[i]    <= eng_sad[i*SAD_W +: SAD_W];
              end
            end
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Engines left out of a partial batch keep their previous offsets.
      if (w_issue) begin
        r_eng_start <= w_mask;
        r_fetch_go  <= 1'b1;
        r_active    <= w_mask;
        r_sticky    <= '0;
        r_cur       <= w_next_cur;
        r_more      <= w_more;
        for (int i = 0; i < NENG; i++) begin
          if (w_mask[i]) begin
            r_eng_u[i] <= MV_W'(w_cand[i].u);
            r_eng_v[i] <= MV_W'(w_cand[i].v);
          end
        end
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign eng_start = r_eng_start;
  assign fetch_go  = r_fetch_go;
  assign res_valid = r_res_valid;
  assign res_mv_u  = r_res_mv_u;
  assign res_mv_v  = r_res_mv_v;
  assign res_cost  = r_res_cost;
endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: behavioural SAD engine array plus a result scoreboard.
// Expectations follow ME_EARLY_TERM_EN when the bench is compiled with that macro.
module tb_me_search_ctrl;
  import me_pkg::*;

  localparam int NENG  = 4;
  localparam int MAX_R = 8;
  localparam int MV_W  = 6;

  typedef struct {
    int u;
    int v;
    int cost;
    int batches;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [4:0]             cmd_radius;
  logic signed [MV_W-1:0] cmd_pmv_u;
  logic signed [MV_W-1:0] cmd_pmv_v;
  logic [7:0]             cmd_lambda;
  logic [COST_W-1:0]      cmd_thresh;
  logic [NENG-1:0]        eng_start;
  logic [NENG*MV_W-1:0]   eng_u;
  logic [NENG*MV_W-1:0]   eng_v;
  logic                   fetch_go;
  logic [NENG-1:0]        eng_done;
  logic [NENG*SAD_W-1:0]  eng_sad;
  logic                   res_valid;
  logic                   res_ready;
  logic signed [MV_W-1:0] res_mv_u;
  logic signed [MV_W-1:0] res_mv_v;
  logic [COST_W-1:0]      res_cost;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  exp_t expQ[$];
  logic [NENG-1:0] startLog[$];
  int sadMode = 0;
  int skewMin = 1;
  int skewMax = 0;
  int fetchCount = 0;
  bit strayEn = 0;
  bit latEnable = 1;

  int cnt [NENG];
  int pu  [NENG];
  int pv  [NENG];
  int pending = 0;
  int doneCycle = 0;
  bit latArmed = 0;
  logic [NENG-1:0] lastStart = '0;

  me_search_ctrl #(.NENG(NENG), .MAX_R(MAX_R), .MV_W(MV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_radius(cmd_radius),
    .cmd_pmv_u (cmd_pmv_u),
    .cmd_pmv_v (cmd_pmv_v),
    .cmd_lambda(cmd_lambda),
    .cmd_thresh(cmd_thresh),
    .eng_start (eng_start),
    .eng_u     (eng_u),
    .eng_v     (eng_v),
    .fetch_go  (fetch_go),
    .eng_done  (eng_done),
    .eng_sad   (eng_sad),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_mv_u  (res_mv_u),
    .res_mv_v  (res_mv_v),
    .res_cost  (res_cost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic int sadOf(int u, int v, int mode);
    int s;
    case (mode)
      0: s = (u == 0 && v == 0) ? 40 : 100;
      1: begin
        if (u == 1 && v == 1) s = 50;
        else if (u == 0 && v == 0) s = 48;
        else s = 200;
      end
      2: s = 10;
      3: s = ((u + 20) * 131 + (v + 20) * 71) % 997;
      default: s = (v == -4 && u < 0) ? 20 : 500;
    endcase
    return s;
  endfunction

  function automatic int absInt(int x);
    return (x < 0) ? -x : x;
  endfunction

  // Sequential raster walk over the window; batches close every NENG candidates.
  function automatic exp_t computeExpected(int radius, int pmvU, int pmvV, int lam, int thr, int mode);
    exp_t e;
    int r, n, total, cost;
    bit stopped;
    r = (radius > MAX_R) ? MAX_R : radius;
    total = (2 * r + 1) * (2 * r + 1);
    e.u = 0;
    e.v = 0;
    e.cost = 262143;
    e.batches = 0;
    n = 0;
    stopped = 0;
    for (int v = -r; v <= r; v++) begin
      for (int u = -r; u <= r; u++) begin
        if (!stopped) begin
          cost = sadOf(u, v, mode) + lam * (absInt(u - pmvU) + absInt(v - pmvV));
          if (cost < e.cost) begin
            e.cost = cost;
            e.u = u;
            e.v = v;
          end
          n++;
          if ((n % NENG) == 0 || n == total) begin
            e.batches++;
`ifdef ME_EARLY_TERM_EN
            if (e.cost <= thr) stopped = 1;
`else
            if (thr < 0) stopped = 1;
`endif
          end
        end
      end
    end
    return e;
  endfunction

  task automatic compareValue(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    compareValue({tag, "_cmd_ready"}, cmd_ready, 1);
    compareValue({tag, "_eng_start"}, eng_start, 0);
    compareValue({tag, "_fetch_go"},  fetch_go, 0);
    compareValue({tag, "_eng_u"},     eng_u, 0);
    compareValue({tag, "_eng_v"},     eng_v, 0);
    compareValue({tag, "_res_valid"}, res_valid, 0);
    compareValue({tag, "_res_mv_u"},  res_mv_u, 0);
    compareValue({tag, "_res_mv_v"},  res_mv_v, 0);
    compareValue({tag, "_res_cost"},  res_cost, 0);
  endtask

  task automatic applyStimulus(input int radius, input int pmvU, input int pmvV,
                               input int lam, input int thr, input int mode);
    @(negedge clk);
    compareValue("cmd_ready_idle", cmd_ready, 1);
    fetchCount = 0;
    startLog.delete();
    sadMode    = mode;
    cmd_radius = 5'(radius);
    cmd_pmv_u  = MV_W'(pmvU);
    cmd_pmv_v  = MV_W'(pmvV);
    cmd_lambda = 8'(lam);
    cmd_thresh = COST_W'(thr);
    cmd_valid  = 1'b1;
    expQ.push_back(computeExpected(radius, pmvU, pmvV, lam, thr, mode));
    @(negedge clk);
    cmd_valid = 1'b0;
    compareValue("issue_fetch_go", fetch_go, 1);
    compareValue("issue_eng0_start", eng_start[0], 1);
  endtask

  task automatic checkOutput(input string tag, input int holdCycles);
    exp_t e;
    int waitCnt;
    waitCnt = 0;
    while (res_valid !== 1'b1 && waitCnt < 5000) begin
      @(negedge clk);
      waitCnt++;
    end
    compareValue({tag, "_res_valid"}, res_valid, 1);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = expQ.pop_front();
    compareValue({tag, "_mv_u"},    res_mv_u, e.u);
    compareValue({tag, "_mv_v"},    res_mv_v, e.v);
    compareValue({tag, "_cost"},    res_cost, e.cost);
    compareValue({tag, "_batches"}, fetchCount, e.batches);
    compareValue({tag, "_busy"},    cmd_ready, 0);
    for (int k = 0; k < holdCycles; k++) begin
      @(negedge clk);
      compareValue({tag, "_hold_valid"}, res_valid, 1);
      compareValue({tag, "_hold_mv_u"},  res_mv_u, e.u);
      compareValue({tag, "_hold_mv_v"},  res_mv_v, e.v);
      compareValue({tag, "_hold_cost"},  res_cost, e.cost);
      compareValue({tag, "_hold_busy"},  cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    compareValue({tag, "_released"}, res_valid, 0);
    compareValue({tag, "_idle"},     cmd_ready, 1);
  endtask

  // Engine array model: each started engine answers after a random skew with the SAD of its offset.
  initial begin
    logic signed [MV_W-1:0] tu, tv;
    eng_done = '0;
    eng_sad  = '0;
    for (int i = 0; i < NENG; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      eng_done = '0;
      for (int i = 0; i < NENG; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            eng_done[i] = 1'b1;
            eng_sad[i*SAD_W +: SAD_W] = SAD_W'(sadOf(pu[i], pv[i], sadMode));
            pending--;
            if (pending == 0) begin
              doneCycle = cycle;
              latArmed  = 1;
            end
          end
        end
      end
      if (strayEn && pending > 0) begin
        for (int i = 0; i < NENG; i++) begin
          if (!lastStart[i]) begin
            eng_done[i] = 1'b1;
            eng_sad[i*SAD_W +: SAD_W] = '0;
          end
        end
      end
      if (!latEnable) latArmed = 0;
      if (latArmed && (cycle - doneCycle) >= 2) begin
        compareValue("batch_latency", (fetch_go || res_valid), 1);
        latArmed = 0;
      end
      if (fetch_go) fetchCount++;
      if (|eng_start) begin
        lastStart = eng_start;
        startLog.push_back(eng_start);
        for (int i = 0; i < NENG; i++) begin
          if (eng_start[i]) begin
            tu = eng_u[i*MV_W +: MV_W];
            tv = eng_v[i*MV_W +: MV_W];
            pu[i]  = tu;
            pv[i]  = tv;
            cnt[i] = skewMin + int'($urandom_range(skewMax, 0));
            pending++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NENG-1:0] expMasks [3];
    int waitCnt;
    expMasks[0] = 4'b1111;
    expMasks[1] = 4'b1111;
    expMasks[2] = 4'b0001;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_radius = '0;
    cmd_pmv_u  = '0;
    cmd_pmv_v  = '0;
    cmd_lambda = '0;
    cmd_thresh = '0;
    res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkResetValues("post_reset");

    $display("[TB] single minimum at origin, R=1");
    skewMax = 3;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t1", 0);
    compareValue("t1_issue_count", startLog.size(), 3);
    for (int i = 0; i < 3 && i < startLog.size(); i++)
      compareValue($sformatf("t1_mask%0d", i), startLog[i], expMasks[i]);

    $display("[TB] rate term overrides lower SAD");
    applyStimulus(1, 1, 1, 4, 0, 1);
    checkOutput("t2", 0);

    $display("[TB] all-equal SADs keep first candidate");
    applyStimulus(2, 0, 0, 0, 0, 2);
    checkOutput("t3", 0);

    $display("[TB] skewed done and stray pulses on idle engines");
    skewMax = 20;
    strayEn = 1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t4", 0);
    strayEn = 0;

    $display("[TB] zero radius");
    skewMax = 2;
    applyStimulus(0, 2, -1, 3, 0, 3);
    checkOutput("t5", 0);
    compareValue("t5_mask", startLog.size() > 0 ? startLog[0] : 4'b0000, 4'b0001);

    $display("[TB] radius clamp");
    skewMax = 4;
    applyStimulus(20, -3, 5, 2, 0, 3);
    checkOutput("t6", 0);

    $display("[TB] consumer backpressure");
    applyStimulus(2, 1, -1, 1, 0, 3);
    checkOutput("t7", 10);

    $display("[TB] threshold command");
    skewMax = 3;
    applyStimulus(4, 0, 0, 0, 30, 4);
    checkOutput("t8", 0);

    $display("[TB] reset during WAIT");
    latEnable = 0;
    skewMin = 15;
    skewMax = 5;
    applyStimulus(3, 0, 0, 0, 0, 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_reset");
    void'(expQ.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkResetValues("after_reset");
    waitCnt = 0;
    while (pending > 0 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    @(negedge clk);
    compareValue("stale_done_valid", res_valid, 0);
    compareValue("stale_done_ready", cmd_ready, 1);
    compareValue("stale_done_start", eng_start, 0);
    skewMin = 1;
    skewMax = 3;
    latEnable = 1;
    applyStimulus(1, 0, 0, 4, 0, 1);
    checkOutput("t9", 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
